// File: rtl/partial_state_shuttle.sv
// Serial shuttle for lifted partial-circuit state: snapshots lifted_output out, shifts lifted_input in, commits atomically.
// Optional even-parity beat on both streams when PARTIAL_SHUTTLE_PARITY_EN is defined.
module partial_state_shuttle #(
    parameter int              N_OUT   = 3,
    parameter int              N_IN    = 4,
    parameter logic [N_IN-1:0] INIT_IN = '0
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] lifted_output,
    output logic [N_IN-1:0]  lifted_input,
    output logic             so_valid,
    input  logic             so_ready,
    output logic             so_data,
    input  logic             si_valid,
    output logic             si_ready,
    input  logic             si_data,
    output logic             busy,
    output logic             done,
    output logic             err
);
`ifdef PARTIAL_SHUTTLE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int              OUT_W   = N_OUT + PAR;
    localparam int              IN_W    = N_IN + PAR;
    localparam int              CW      = 7;
    localparam logic [CW-1:0]   OUT_LIM = CW'(OUT_W);
    localparam logic [CW-1:0]   IN_LIM  = CW'(IN_W);
    localparam logic [IN_W-1:0] IN_MSB  = IN_W'(1) << (IN_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t           r_state, w_next;
    logic [OUT_W-1:0] r_out_sr;
    logic [IN_W-1:0]  r_in_sr;
    logic [CW-1:0]    r_out_cnt, r_in_cnt;
    logic [N_IN-1:0]  r_lifted;
    logic [OUT_W-1:0] w_snapshot;
    logic             w_out_more, w_in_more, w_so_beat, w_si_beat, w_par_ok;

`ifdef PARTIAL_SHUTTLE_PARITY_EN
    assign w_snapshot = {^lifted_output, lifted_output};
    assign w_par_ok   = ((^r_in_sr[N_IN-1:0]) == r_in_sr[N_IN]);
`else
    assign w_snapshot = lifted_output;
    assign w_par_ok   = 1'b1;
`endif

    assign w_out_more   = (r_out_cnt < OUT_LIM);
    assign w_in_more    = (r_in_cnt < IN_LIM);
    assign w_so_beat    = so_valid & so_ready;
    assign w_si_beat    = si_valid & si_ready;
    assign so_data      = r_out_sr[0];
    assign lifted_input = r_lifted;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SHIFT;
            S_SHIFT: begin
                if (abort)                           w_next = S_IDLE;
                else if (!w_out_more && !w_in_more)  w_next = S_COMMIT;
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        so_valid = 1'b0;
        si_ready = 1'b0;
        busy     = (r_state != S_IDLE);
        done     = 1'b0;
        err      = 1'b0;
        case (r_state)
            S_SHIFT: begin
                so_valid = w_out_more;
                si_ready = w_in_more;
            end
            S_COMMIT: begin
                done = w_par_ok;
`ifdef PARTIAL_SHUTTLE_PARITY_EN
                err  = !w_par_ok;
`endif
            end
            default: ;
        endcase
    end

    // Shift registers, beat counters and the committed lifted_input drive.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_out_sr  <= '0;
            r_in_sr   <= '0;
            r_out_cnt <= '0;
            r_in_cnt  <= '0;
            r_lifted  <= INIT_IN;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_out_sr  <= w_snapshot;
                r_in_sr   <= '0;
                r_out_cnt <= '0;
                r_in_cnt  <= '0;
            end else begin
                if (w_so_beat) begin
                    r_out_sr  <= r_out_sr >> 1;
                    r_out_cnt <= r_out_cnt + CW'(1);
                end
                // New bits enter at the top so the first bit ends up in bit 0.
                if (w_si_beat) begin
                    r_in_sr  <= (r_in_sr >> 1) | (si_data ? IN_MSB : '0);
                    r_in_cnt <= r_in_cnt + CW'(1);
                end
            end
            if (r_state == S_COMMIT && w_par_ok) begin
                r_lifted <= r_in_sr[N_IN-1:0];
            end
        end
    end
endmodule
